// File: rtl/seg_scan_ctrl.sv
// Millisecond timer display: captures a 17-bit ms value, converts it to six BCD
// digits by serial double-dabble, and multiplexes them onto a 6-digit 7-segment display.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 8,
  parameter int LZB       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [16:0] ms_value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [7:0]  seg,
  output logic [5:0]  dig_sel
);

  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, COMMIT = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [16:0]   shift_q, shift_d;
  logic [23:0]   bcd_q, bcd_d, adj_s;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [23:0]   disp_q, disp_d;
  logic          done_q, done_d;
  logic [CW-1:0] scan_q, scan_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    seg_q, seg_d;
  logic [5:0]    dig_sel_q, dig_sel_d;
  logic [3:0]    nib_s;
  logic          blank_s;
  logic          busy_s;

  function automatic logic [23:0] bcd_adj(input logic [23:0] b);
    logic [23:0] r;
    r = b;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [7:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 8'b11111100;
      4'd1:    digit_seg = 8'b01100000;
      4'd2:    digit_seg = 8'b11011010;
      4'd3:    digit_seg = 8'b11110010;
      4'd4:    digit_seg = 8'b01100110;
      4'd5:    digit_seg = 8'b10110110;
      4'd6:    digit_seg = 8'b10111110;
      4'd7:    digit_seg = 8'b11100000;
      4'd8:    digit_seg = 8'b11111110;
      4'd9:    digit_seg = 8'b11110110;
      default: digit_seg = 8'b00000000;
    endcase
  endfunction

  assign adj_s = bcd_adj(bcd_q);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: CONV runs exactly 17 cycles (bit_cnt 0..16)
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CONV; else state_d = IDLE;
      CONV:    if (bit_cnt_q == 5'd16) state_d = COMMIT; else state_d = CONV;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_s = 1'b0;
    case (state_q)
      CONV, COMMIT: busy_s = 1'b1;
      default:      busy_s = 1'b0;
    endcase
  end

  // Conversion datapath next-state; display registers change only leaving COMMIT
  always_comb begin
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    disp_d    = disp_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d   = ms_value;
          bcd_d     = 24'd0;
          bit_cnt_d = 5'd0;
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      CONV: begin
        bcd_d     = {adj_s[22:0], shift_q[16]};
        shift_d   = {shift_q[15:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
      COMMIT: begin
        disp_d = bcd_q;
        done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Conversion datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= 17'd0;
      bcd_q     <= 24'd0;
      bit_cnt_q <= 5'd0;
      disp_q    <= 24'd0;
      done_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      disp_q    <= disp_d;
      done_q    <= done_d;
    end
  end

  // Scan timing and per-digit output decode; uses next-state values so the
  // registered outputs line up with the counter they describe
  always_comb begin
    idx_d = idx_q;
    if (scan_q == CW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      if (idx_q == 3'd5) idx_d = 3'd0; else idx_d = idx_q + 3'd1;
    end else begin
      scan_d = scan_q + CW'(1);
    end

    case (idx_d)
      3'd0:    nib_s = disp_d[3:0];
      3'd1:    nib_s = disp_d[7:4];
      3'd2:    nib_s = disp_d[11:8];
      3'd3:    nib_s = disp_d[15:12];
      3'd4:    nib_s = disp_d[19:16];
      3'd5:    nib_s = disp_d[23:20];
      default: nib_s = 4'd0;
    endcase

    blank_s = (LZB != 0) &&
              (((idx_d == 3'd5) && (disp_d[23:20] == 4'd0)) ||
               ((idx_d == 3'd4) && (disp_d[23:20] == 4'd0) && (disp_d[19:16] == 4'd0)));

    if (blank_s) seg_d = 8'd0;
    else         seg_d = digit_seg(nib_s) | {7'd0, (idx_d == 3'd3)};

    if (scan_d < CW'(BLANK_CYC)) begin
      dig_sel_d = 6'd0;
    end else begin
      case (idx_d)
        3'd0:    dig_sel_d = 6'b000001;
        3'd1:    dig_sel_d = 6'b000010;
        3'd2:    dig_sel_d = 6'b000100;
        3'd3:    dig_sel_d = 6'b001000;
        3'd4:    dig_sel_d = 6'b010000;
        3'd5:    dig_sel_d = 6'b100000;
        default: dig_sel_d = 6'b000000;
      endcase
    end
  end

  // Scan counter and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q    <= '0;
      idx_q     <= 3'd0;
      seg_q     <= 8'd0;
      dig_sel_q <= 6'd0;
    end else begin
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign busy    = busy_s;
  assign done    = done_q;
  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clock cycles per digit slot (legal >= 4).
REQ-002 SHALL have parameter BLANK_CYC, default 8, leading cycles of each slot with all digits off (legal < SCAN_DIV).
REQ-003 SHALL have parameter LZB, default 1; 1 = leading-zero blanking enabled.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ms_value, input, 17, elapsed time in ms (0..131071).
REQ-007 SHALL have port load, input, 1, capture-and-convert request.
REQ-008 SHALL have port busy, output, 1, conversion in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when a new value is committed to the display.
REQ-010 SHALL have port seg, output, 8, segments [A,B,C,D,E,F,G,DP] at bits 7..0, active high.
REQ-011 SHALL have port dig_sel, output, 6, one-hot digit enable, active high; bit 5 = hundreds of seconds, bit 0 = ms units.

Function
REQ-012 SHALL run an FSM with states IDLE, CONV, COMMIT.
REQ-013 SHALL, in IDLE with load=1, capture ms_value and enter CONV next cycle; load outside IDLE SHALL be ignored (no queueing).
REQ-014 SHALL perform binary-to-BCD conversion in CONV by sequential shift-add-3 over exactly 17 cycles (one input bit per cycle, MSB first) into six 4-bit BCD digits.
REQ-015 SHALL enter COMMIT after the 17th CONV cycle, copy the BCD result into display registers at the end of COMMIT, and return to IDLE.
REQ-016 SHALL assert busy in every CONV and COMMIT cycle (18 cycles); busy SHALL be low in IDLE.
REQ-017 SHALL pulse done for one cycle, the first IDLE cycle after COMMIT; load sampled in that cycle SHALL be accepted.
REQ-018 SHALL leave displayed digits unchanged until the COMMIT edge (atomic update; no partial values visible).
REQ-019 SHALL run a scan counter 0..SCAN_DIV-1 continuously, independent of FSM state; on wrap the digit index SHALL advance 0,1,2,3,4,5,0...
REQ-020 SHALL drive dig_sel=0 while scan counter < BLANK_CYC, else one-hot of the digit index.
REQ-021 SHALL drive seg with the current digit's pattern: 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110, 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11110110 (DP bit shown as 0).
REQ-022 SHALL set seg bit 0 (DP) only when digit index = 3 (seconds/ms boundary, display "SSS.mmm").
REQ-023 SHALL, with LZB=1, drive seg=00000000 for digit 5 if it is 0, and for digit 4 if digits 5 and 4 are both 0; digits 3..0 SHALL never be blanked.
REQ-024 SHALL register seg and dig_sel (glitch-free outputs), both changing on the same edge.

Reset
REQ-025 SHALL, on rst_n=0, immediately force FSM=IDLE, busy=0, done=0, scan counter=0, digit index=0, dig_sel=0, seg=0, display registers=0.
REQ-026 SHALL, on rst_n deassertion mid-conversion, discard the partial result; display SHALL show 000.000 (blanked digits per LZB).
REQ-027 SHALL resume scanning the first cycle after rst_n deasserts, starting at digit 0 with a blank window.

Verification
REQ-028 SHALL verify: reset, no load, SCAN_DIV=10, BLANK_CYC=2 -> dig_sel cycles 000001..100000 (8 active cycles each), digit 3 seg=11111101, digit 0 seg=11111100, digits 5/4 seg=0.
REQ-029 SHALL verify: load with ms_value=12345 -> busy high exactly 18 cycles, done pulse next cycle, display digits 0,1,2,3,4,5 (LZB blanks digit 5, digit 4 shows 1, digit 3 shows 2 with DP).
REQ-030 SHALL verify: ms_value=131071 -> digits 1,3,1,0,7,1 (hundreds..ms), no blanking; ms_value=0 -> 000.000 shown as "  0.000".
REQ-031 SHALL verify: load pulsed during CONV with a different value -> ignored, committed value is the first; load in done cycle accepted.
REQ-032 SHALL verify: rst_n pulsed low at CONV cycle 9 -> busy=0 and dig_sel=0 asynchronously, no done pulse, display later shows 0.
REQ-033 SHALL verify: load at scan wrap boundary -> scan sequence unperturbed, display value switches only at COMMIT edge.
